hub75_rx: RTL and testbench

//   Receive side of the HUB75 panel interface. It samples an external HUB75 bus
//   (CK, LA, BL, row address, two RGB lanes) and reconstructs each latched line.

---
 rtl/hub75_rx.sv | 184 ++++++++++++++++++
 tb/tb_hub75_rx.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_rx.sv
// HUB75 receive side: samples an external HUB75 bus, rebuilds each latched
// line and replays it as a stream of pixel writes into a frame memory.
// Pixel order in the line: column 0 is the most recently shifted pixel.
// Handshake: wr_en is a push-only strobe. One pixel is valid on every cycle that
// wr_en is high. There is no back-pressure, so the sink must accept one write per cycle.
module hub75_rx #(
  parameter int WIDTH       = 64,
  parameter int ADDR_W      = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     hub_ck,
  input  logic                     hub_la,
  input  logic                     hub_bl,
  input  logic [ADDR_W-1:0]        hub_addr,
  input  logic [2:0]               hub_rgb0,
  input  logic [2:0]               hub_rgb1,
  input  logic                     err_clr,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_row,
  output logic [$clog2(WIDTH)-1:0] wr_col,
  output logic [2:0]               wr_rgb0,
  output logic [2:0]               wr_rgb1,
  output logic                     line_done,
  output logic                     blank,
  output logic                     err_short,
  output logic                     err_ovr
);

  localparam int COL_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BUS_W = 3 + ADDR_W + 6;

  typedef enum logic {IDLE, DRAIN} state_t;

  // Synchronizer: every lane has the same depth so data stays aligned with CK.
  logic [BUS_W-1:0] sync_d [SYNC_STAGES];
  logic [BUS_W-1:0] sync_q [SYNC_STAGES];

  logic              s_ck, s_la, s_bl;
  logic [ADDR_W-1:0] s_addr;
  logic [5:0]        s_pix;

  logic ck_prev_q, la_prev_q;
  logic ck_rise, la_rise;

  logic [5:0]        shreg_d [WIDTH];
  logic [5:0]        shreg_q [WIDTH];
  logic [5:0]        line_d  [WIDTH];
  logic [5:0]        line_q  [WIDTH];
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  state_t            state_d, state_q;
  logic              wr_en_d, wr_en_q;
  logic [ADDR_W-1:0] wr_row_d, wr_row_q;
  logic [COL_W-1:0]  wr_col_d, wr_col_q;
  logic [COL_W-1:0]  col_nxt;
  logic [5:0]        wr_pix_d, wr_pix_q;
  logic              line_done_d, line_done_q;
  logic              blank_d, blank_q;
  logic              err_short_d, err_short_q;
  logic              err_ovr_d, err_ovr_q;

  // Synchronizer next-state: stage 0 takes the raw bus, later stages shift.
  always_comb begin
    sync_d[0] = {hub_ck, hub_la, hub_bl, hub_addr, hub_rgb0, hub_rgb1};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Synchronizer flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
    end
  end

  assign {s_ck, s_la, s_bl, s_addr, s_pix} = sync_q[SYNC_STAGES-1];
  assign ck_rise = s_ck & ~ck_prev_q;
  assign la_rise = s_la & ~la_prev_q;
  assign col_nxt = wr_col_q + COL_W'(1);

  // Next-state logic: shift on CK, accept or reject latches, step the drain.
  always_comb begin
    shreg_d     = shreg_q;
    line_d      = line_q;
    cnt_d       = cnt_q;
    state_d     = state_q;
    wr_en_d     = 1'b0;
    wr_row_d    = wr_row_q;
    wr_col_d    = wr_col_q;
    wr_pix_d    = wr_pix_q;
    line_done_d = 1'b0;
    blank_d     = s_bl;
    err_short_d = err_short_q & ~err_clr;
    err_ovr_d   = err_ovr_q & ~err_clr;

    // A shift goes first, so a latch in the same cycle captures this pixel.
    if (ck_rise) begin
      for (int i = WIDTH - 1; i > 0; i--) shreg_d[i] = shreg_q[i-1];
      shreg_d[0] = s_pix;
      if (cnt_q != CNT_W'(WIDTH)) cnt_d = cnt_q + CNT_W'(1);
    end

    // Drain steps one column per cycle from the frozen line buffer.
    if (state_q == DRAIN) begin
      if (wr_col_q == COL_W'(WIDTH - 1)) begin
        state_d = IDLE;
      end else begin
        wr_en_d     = 1'b1;
        wr_col_d    = col_nxt;
        wr_pix_d    = line_q[col_nxt];
        line_done_d = (col_nxt == COL_W'(WIDTH - 1));
      end
    end

    // Latch: accepted only while idle. A latch during a drain is dropped.
    if (la_rise) begin
      if (cnt_d < CNT_W'(WIDTH)) err_short_d = 1'b1;
      cnt_d = '0;
      if (state_q == IDLE) begin
        line_d   = shreg_d;
        wr_row_d = s_addr;
        state_d  = DRAIN;
        wr_en_d  = 1'b1;
        wr_col_d = '0;
        wr_pix_d = shreg_d[0];
      end else begin
        err_ovr_d = 1'b1;
      end
    end
  end

  // State and output registers; async reset abandons any drain at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ck_prev_q   <= 1'b0;
      la_prev_q   <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        shreg_q[i] <= '0;
        line_q[i]  <= '0;
      end
      cnt_q       <= '0;
      state_q     <= IDLE;
      wr_en_q     <= 1'b0;
      wr_row_q    <= '0;
      wr_col_q    <= '0;
      wr_pix_q    <= '0;
      line_done_q <= 1'b0;
      blank_q     <= 1'b0;
      err_short_q <= 1'b0;
      err_ovr_q   <= 1'b0;
    end else begin
      ck_prev_q   <= s_ck;
      la_prev_q   <= s_la;
      shreg_q     <= shreg_d;
      line_q      <= line_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      wr_en_q     <= wr_en_d;
      wr_row_q    <= wr_row_d;
      wr_col_q    <= wr_col_d;
      wr_pix_q    <= wr_pix_d;
      line_done_q <= line_done_d;
      blank_q     <= blank_d;
      err_short_q <= err_short_d;
      err_ovr_q   <= err_ovr_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_row    = wr_row_q;
  assign wr_col    = wr_col_q;
  assign wr_rgb0   = wr_pix_q[5:3];
  assign wr_rgb1   = wr_pix_q[2:0];
  assign line_done = line_done_q;
  assign blank     = blank_q;
  assign err_short = err_short_q;
  assign err_ovr   = err_ovr_q;

endmodule

// File: tb/tb_hub75_rx.sv
// Bench for hub75_rx: directed sequence with random pixel data, checked against
// a pixel-history model (every pixel ever shifted since reset, newest last).
module tb_hub75_rx;
  localparam int WIDTH  = 64;
  localparam int ADDR_W = 5;
  localparam int SYNC   = 2;

  // Clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              hub_ck = 1'b0, hub_la = 1'b0, hub_bl = 1'b0, err_clr = 1'b0;
  logic [ADDR_W-1:0] hub_addr = '0;
  logic [2:0]        hub_rgb0 = '0, hub_rgb1 = '0;
  logic              wr_en, line_done, blank, err_short, err_ovr;
  logic [ADDR_W-1:0] wr_row;
  logic [5:0]        wr_col;
  logic [2:0]        wr_rgb0, wr_rgb1;

  hub75_rx #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .hub_ck(hub_ck), .hub_la(hub_la), .hub_bl(hub_bl),
    .hub_addr(hub_addr), .hub_rgb0(hub_rgb0), .hub_rgb1(hub_rgb1), .err_clr(err_clr),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_rgb0(wr_rgb0), .wr_rgb1(wr_rgb1),
    .line_done(line_done), .blank(blank), .err_short(err_short), .err_ovr(err_ovr)
  );

  // Write monitor: samples 2 ns after each rising edge.
  typedef struct packed {
    logic [ADDR_W-1:0] row;
    logic [5:0]        col;
    logic [5:0]        pix;
    logic              done;
    logic [31:0]       cyc;
  } wr_t;
  wr_t mon_q[$];
  int  cyc = 0;
  int  done_cnt = 0;

  always @(posedge clk) begin
    wr_t w;
    #2;
    cyc++;
    if (line_done) done_cnt++;
    if (wr_en) begin
      w.row  = wr_row;
      w.col  = wr_col;
      w.pix  = {wr_rgb0, wr_rgb1};
      w.done = line_done;
      w.cyc  = cyc;
      mon_q.push_back(w);
    end
  end

  // Reference model state
  logic [5:0]        hist[$];
  int                since_la = 0;
  logic              m_short = 1'b0, m_ovr = 1'b0;
  logic [ADDR_W-1:0] exp_row;
  logic [5:0]        exp_line[WIDTH];
  logic [5:0]        got_line[WIDTH];
  int                la_cyc;

  // Scoreboard counters
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks (all called at a falling edge of clk)
  task automatic send_px(input logic [2:0] r0, input logic [2:0] r1);
    hub_ck = 1'b0; hub_rgb0 = r0; hub_rgb1 = r1;
    repeat (2) @(negedge clk);
    hub_ck = 1'b1;
    hist.push_back({r0, r1});
    since_la++;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_rand(input int n);
    for (int i = 0; i < n; i++)
      send_px(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
  endtask

  // Accepted latch: expected line is the newest WIDTH pixels, newest in column 0.
  task automatic model_latch(input logic [ADDR_W-1:0] a, input logic clr);
    if (clr) begin m_short = 1'b0; m_ovr = 1'b0; end
    if (since_la < WIDTH) m_short = 1'b1;
    since_la = 0;
    exp_row  = a;
    for (int c = 0; c < WIDTH; c++) begin
      int idx;
      idx = hist.size() - 1 - c;
      exp_line[c] = (idx >= 0) ? hist[idx] : 6'd0;
    end
  endtask

  task automatic do_latch(input logic [ADDR_W-1:0] a, input logic clr);
    hub_addr = a; hub_la = 1'b1; la_cyc = cyc;
    model_latch(a, clr);
    repeat (2) @(negedge clk);
    if (clr) err_clr = 1'b1;
    hub_la = 1'b0;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_short = 1'b0; m_ovr = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_errs(input string tag);
    chk($sformatf("%s_err_short", tag), err_short, m_short);
    chk($sformatf("%s_err_ovr", tag), err_ovr, m_ovr);
  endtask

  task automatic check_line(input string tag);
    wr_t w;
    for (int k = 0; k < 400 && mon_q.size() < WIDTH; k++) @(negedge clk);
    chk($sformatf("%s_nwrites", tag), mon_q.size(), WIDTH);
    if (mon_q.size() < WIDTH) return;
    for (int i = 0; i < WIDTH; i++) begin
      w = mon_q.pop_front();
      got_line[i] = w.pix;
      chk($sformatf("%s_col%0d", tag, i), w.col, i);
      chk($sformatf("%s_row%0d", tag, i), w.row, exp_row);
      chk($sformatf("%s_pix%0d", tag, i), w.pix, exp_line[i]);
      chk($sformatf("%s_done%0d", tag, i), w.done, (i == WIDTH - 1));
      chk($sformatf("%s_cyc%0d", tag, i), w.cyc, la_cyc + SYNC + 1 + i);
    end
    repeat (5) @(negedge clk);
    chk($sformatf("%s_extra", tag), mon_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int d0;
    logic [5:0] last_px;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_row", wr_row, 0);
    chk("rst_wr_col", wr_col, 0);
    chk("rst_wr_rgb0", wr_rgb0, 0);
    chk("rst_wr_rgb1", wr_rgb1, 0);
    chk("rst_line_done", line_done, 0);
    chk("rst_blank", blank, 0);
    chk("rst_err_short", err_short, 0);
    chk("rst_err_ovr", err_ovr, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // blank: synchronized then registered
    hub_bl = 1'b1;
    repeat (2) @(negedge clk);
    chk("blank_early", blank, 0);
    @(negedge clk);
    chk("blank_rise", blank, 1);
    hub_bl = 1'b0;
    repeat (4) @(negedge clk);
    chk("blank_fall", blank, 0);

    // 1: full line with a fixed pattern, row 5
    for (int i = 0; i < WIDTH; i++) begin
      logic [2:0] kk;
      kk = 3'(i);
      send_px(kk, ~kk);
    end
    do_latch(5'd5, 1'b0);
    check_line("t1");
    chk("t1_col0_rgb0", got_line[0][5:3], 7);
    chk("t1_col63_rgb0", got_line[63][5:3], 0);
    chk("t1_col0_rgb1", got_line[0][2:0], 0);
    check_errs("t1");

    // 2: short line, with err_clr coinciding with the error event
    send_rand(40);
    do_latch(5'($urandom_range(0, 31)), 1'b1);
    check_line("t2");
    check_errs("t2");
    chk("t2_short_set", err_short, 1);
    clear_errs();
    check_errs("t2_clr");

    // 3: overlong line keeps only the newest pixels
    send_rand(70);
    do_latch(5'($urandom_range(0, 31)), 1'b0);
    check_line("t3");
    check_errs("t3");

    // 4: latch during drain is dropped and flagged
    send_rand(64);
    do_latch(5'd9, 1'b0);
    for (k = 0; k < 200 && mon_q.size() < 10; k++) @(negedge clk);
    hub_addr = 5'd22; hub_la = 1'b1;
    m_ovr = 1'b1;
    if (since_la < WIDTH) m_short = 1'b1;
    since_la = 0;
    repeat (2) @(negedge clk);
    hub_la = 1'b0;
    check_line("t4");
    chk("t4_err_ovr", err_ovr, 1);
    repeat (10) @(negedge clk);
    chk("t4_no_restart", mon_q.size(), 0);
    clear_errs();
    check_errs("t4_clr");

    // 5: CK and LA rise together after 63 pulses
    send_rand(63);
    last_px = 6'($urandom_range(0, 63));
    hub_ck = 1'b0; hub_rgb0 = last_px[5:3]; hub_rgb1 = last_px[2:0];
    repeat (2) @(negedge clk);
    hub_ck = 1'b1;
    hist.push_back(last_px);
    since_la++;
    hub_addr = 5'd17; hub_la = 1'b1; la_cyc = cyc;
    model_latch(5'd17, 1'b0);
    repeat (2) @(negedge clk);
    hub_la = 1'b0;
    repeat (2) @(negedge clk);
    check_line("t5");
    chk("t5_col0_px", got_line[0], last_px);
    check_errs("t5");

    // 6: async reset mid-drain
    send_rand(64);
    do_latch(5'($urandom_range(0, 31)), 1'b0);
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (wr_en === 1'b1 && wr_col === 6'd19) break;
    end
    chk("t6_reached_w20", mon_q.size(), 20);
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    chk("t6_rst_wr_en", wr_en, 0);
    chk("t6_rst_line_done", line_done, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    hist.delete();
    since_la = 0;
    m_short = 1'b0; m_ovr = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_no_done", done_cnt, d0);
    chk("t6_no_more_writes", mon_q.size(), 20);
    mon_q.delete();
    check_errs("t6_after_rst");
    send_rand(64);
    do_latch(5'($urandom_range(0, 31)), 1'b0);
    check_line("t6");
    check_errs("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
